risc_controller: RTL



---
 rtl/risc_pkg.sv | 38 +++
 rtl/risc_controller_phase_counter.sv | 37 +++
 rtl/risc_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : risc_pkg                                                |
// | Description : Shared opcode and phase encodings for the veriiRISC    |
// |               instruction sequencer.                                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package risc_pkg;

  localparam int PHASE_WIDTH = 3;

  // Opcodes
  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  // Phases
  localparam logic [PHASE_WIDTH-1:0] INST_ADDR  = 3'd0;
  localparam logic [PHASE_WIDTH-1:0] INST_FETCH = 3'd1;
  localparam logic [PHASE_WIDTH-1:0] INST_LOAD  = 3'd2;
  localparam logic [PHASE_WIDTH-1:0] IDLE       = 3'd3;
  localparam logic [PHASE_WIDTH-1:0] OP_ADDR    = 3'd4;
  localparam logic [PHASE_WIDTH-1:0] OP_FETCH   = 3'd5;
  localparam logic [PHASE_WIDTH-1:0] ALU_OP     = 3'd6;
  localparam logic [PHASE_WIDTH-1:0] STORE      = 3'd7;

  // Opcodes whose result comes back from memory into the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/risc_controller_phase_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : phase_counter                                           |
// | Description : Wrapping phase counter with synchronous reset and      |
// |               count enable.                                          |
// | Ports       : clk, rst     - clock, sync active-high reset           |
// |               en_i         - advance one phase this cycle            |
// |               count_o      - current phase                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module phase_counter
  import risc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  output logic [PHASE_WIDTH-1:0] count_o
);

  logic [PHASE_WIDTH-1:0] count_q;
  logic [PHASE_WIDTH-1:0] count_d;

  // Natural binary overflow provides the 7 -> 0 wrap.
  assign count_d = en_i ? count_q + PHASE_WIDTH'(1) : count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= INST_ADDR;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/risc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : risc_controller                                         |
// | Description : Eight-phase instruction sequencer for veriiRISC. Decodes|
// |               phase and opcode into datapath load/enable strobes.    |
// | Ports       : clk, rst     - clock, sync active-high reset           |
// |               opcode, zero - IR opcode field, ALU zero flag          |
// |               phase        - current phase (debug)                   |
// |               sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e |
// |                            - datapath and memory control strobes     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module risc_controller
  import risc_pkg::*;
#(
  parameter int OP_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_WIDTH-1:0] opcode,
  input  logic                zero,
  output logic [2:0]          phase,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                halt,
  output logic                inc_pc,
  output logic                ld_ac,
  output logic                ld_pc,
  output logic                wr,
  output logic                data_e
);

  logic                   halted_q;
  logic                   halted_d;
  logic [PHASE_WIDTH-1:0] phase_w;
  logic                   aluop_w;
  logic                   is_hlt_w;
  logic                   is_skz_w;
  logic                   is_sto_w;
  logic                   is_jmp_w;

  assign is_hlt_w = (opcode == HLT);
  assign is_skz_w = (opcode == SKZ);
  assign is_sto_w = (opcode == STO);
  assign is_jmp_w = (opcode == JMP);
  assign aluop_w  = is_aluop(opcode);

  // The halt decision is taken on the edge leaving OP_ADDR; the counter is
  // gated by the next-state flag so that same edge leaves phase parked at 4.
  assign halted_d = halted_q || ((phase_w == OP_ADDR) && is_hlt_w);

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  phase_counter u_phase_counter (
    .clk     (clk),
    .rst     (rst),
    .en_i    (!halted_d),
    .count_o (phase_w)
  );

  assign phase = phase_w;

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = halted_q;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    case (phase_w)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        if (halted_q || is_hlt_w) begin
          halt = 1'b1;
        end else begin
          inc_pc = 1'b1;
        end
      end
      OP_FETCH: begin
        rd = aluop_w;
      end
      ALU_OP: begin
        rd     = aluop_w;
        inc_pc = is_skz_w && zero;
        ld_pc  = is_jmp_w;
        data_e = is_sto_w;
      end
      STORE: begin
        rd     = aluop_w;
        ld_ac  = aluop_w;
        ld_pc  = is_jmp_w;
        data_e = is_sto_w;
        wr     = is_sto_w;
      end
      default: begin
        sel = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
